cog_vid_fifo: RTL

- Small pixel/colour long-pair FIFO that sits directly upstream of the cog video shifter, between the cog's WAITVID issue path and the shifter's pixel/color inputs.
- Lets the cog queue several pixel/colour pairs ahead instead of stalling on every WAITVID.
- Presents the head pair to the shifter and pops it when the shifter's synchronised ack rises, marking that the shifter has latched a new set.
- Flags underrun (shifter latched with no fresh data) and overflow (push while full).

---
 rtl/cog_vid_fifo.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cog_vid_fifo.sv
// rtl/cog_vid_fifo.sv - pixel/colour long-pair FIFO with fall-through head register feeding the cog video shifter
// Optional underrun event counter: define COG_VID_FIFO_STATS_EN.
module cog_vid_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk_cog,
    input  logic          nres,
    input  logic          push,
    input  logic [31:0]   pixel_in,
    input  logic [31:0]   color_in,
    input  logic          ack,
    input  logic          clr_flags,
    output logic [31:0]   pixel,
    output logic [31:0]   color,
    output logic          head_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          underrun,
    output logic          overflow
`ifdef COG_VID_FIFO_STATS_EN
    ,
    output logic [15:0]   underrun_cnt
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          ack_q;

    logic          ack_rise;
    logic          cnt_nz;
    logic          pop_ram;
    logic          bypass;
    logic          ram_write;
    logic          overflow_evt;
    logic          underrun_evt;
    logic [63:0]   ram_head;

    // The head register refills whenever it is empty or being consumed; the RAM
    // has priority so ordering is kept, otherwise a push with nothing stored
    // goes straight into the head.
    always_comb begin
        ack_rise     = ack & ~ack_q;
        cnt_nz       = (count != '0);
        pop_ram      = cnt_nz & (~head_valid | ack_rise);
        bypass       = push & ~cnt_nz & (~head_valid | ack_rise);
        ram_write    = push & ~bypass & ((count != FULL_CNT) | pop_ram);
        overflow_evt = push & ~bypass & (count == FULL_CNT) & ~pop_ram;
        underrun_evt = ack_rise & ~head_valid;
        ram_head     = mem[rd_ptr];
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0) & ~head_valid;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_cog) begin
        if (ram_write) begin
            mem[wr_ptr] <= {pixel_in, color_in};
        end
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= ack;
            if (ram_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ram) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({ram_write, pop_ram})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // When the head drains without a refill, pixel/color hold so the shifter repeats.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            pixel      <= '0;
            color      <= '0;
            head_valid <= 1'b0;
        end else if (pop_ram) begin
            pixel      <= ram_head[63:32];
            color      <= ram_head[31:0];
            head_valid <= 1'b1;
        end else if (bypass) begin
            pixel      <= pixel_in;
            color      <= color_in;
            head_valid <= 1'b1;
        end else if (ack_rise) begin
            head_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (underrun_evt) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef COG_VID_FIFO_STATS_EN
    // Unlike the sticky flags, a clear beats a coincident increment here.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            underrun_cnt <= '0;
        end else if (clr_flags) begin
            underrun_cnt <= '0;
        end else if (underrun_evt && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule
